add_1bit_half: RTL and testbench

- Single-bit half adder: sum = A XOR B, carry = A AND B.
- Primitive building block of the calc/add arithmetic library; feeds full adders and wider ripple/carry structures.
- Result path is selectable at elaboration: pure combinational, or one-cycle registered with valid flag.
- Includes a saturating carry-event counter for datapath statistics.

---
 rtl/add_1bit_half_if.sv | 46 ++++
 rtl/add_1bit_half.sv | 97 +++++++++
 tb/tb_add_1bit_half.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_1bit_half_if.sv
// -----------------------------------------------------------------------------
// add_1bit_half_if
// Purpose : Bundles the operand/result signals of the single-bit half adder.
//           clk and reset are not part of the bundle; they stay plain ports
//           on the module.
// Signals :
//   i_en       operand-valid qualifier (driven by master)
//   i_num_a    operand A               (driven by master)
//   i_num_b    operand B               (driven by master)
//   o_res      sum bit   A ^ B         (driven by slave)
//   o_cry      carry bit A & B         (driven by slave)
//   o_vld      o_res/o_cry qualify a sampled operand pair (driven by slave)
//   o_cnt_cry  saturating count of enabled carry events   (driven by slave)
// Modports: master = operand source, slave = the adder.
// -----------------------------------------------------------------------------
interface add_1bit_half_if #(
   parameter int P_CNT_W = 8
);
   logic               i_en;
   logic               i_num_a;
   logic               i_num_b;
   logic               o_res;
   logic               o_cry;
   logic               o_vld;
   logic [P_CNT_W-1:0] o_cnt_cry;

   modport master (
      output i_en,
      output i_num_a,
      output i_num_b,
      input  o_res,
      input  o_cry,
      input  o_vld,
      input  o_cnt_cry
   );

   modport slave (
      input  i_en,
      input  i_num_a,
      input  i_num_b,
      output o_res,
      output o_cry,
      output o_vld,
      output o_cnt_cry
   );
endinterface

// File: rtl/add_1bit_half.sv
// -----------------------------------------------------------------------------
// add_1bit_half
// Purpose : Single-bit half adder (sum = A ^ B, carry = A & B). This is the
//           primitive cell of the add library. The result path is chosen at
//           elaboration:
//             P_REG_OUT = 0 : o_res/o_cry are combinational and o_vld = i_en.
//             P_REG_OUT = 1 : one-cycle registered result with a valid flag.
//                             On idle cycles the result holds its last value.
//           A saturating counter records how many enabled operations
//           produced a carry, for datapath statistics. It counts in both
//           modes.
// Parameters:
//   P_REG_OUT  0 = combinational result, 1 = registered result
//   P_CNT_W    width of o_cnt_cry (1..32). Must match the interface P_CNT_W.
// Ports:
//   i_clk      clock; all state updates on the rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        add_1bit_half_if.slave (operands in, result/valid/count out)
// -----------------------------------------------------------------------------
module add_1bit_half #(
   parameter int P_REG_OUT = 0,
   parameter int P_CNT_W   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   add_1bit_half_if.slave   bus
);

   localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

   logic sum_c;
   logic cry_c;
   logic cnt_inc;

   assign sum_c = bus.i_num_a ^ bus.i_num_b;
   assign cry_c = bus.i_num_a & bus.i_num_b;

   // i_en gates the operands first. Because 0 && X resolves to 0,
   // undriven operands on idle cycles cannot bump the counter.
   assign cnt_inc = bus.i_en && cry_c;

   // -------------------------------------------------------------------------
   // Carry-event counter: increments on enabled carries and sticks at
   // all-ones instead of wrapping.
   // -------------------------------------------------------------------------
   logic [P_CNT_W-1:0] cnt_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_reg <= '0;
      end else if (cnt_inc && (cnt_reg != CNT_MAX)) begin
         cnt_reg <= cnt_reg + CNT_ONE;
      end
   end

   assign bus.o_cnt_cry = cnt_reg;

   // -------------------------------------------------------------------------
   // Result path
   // -------------------------------------------------------------------------
   generate
      if (P_REG_OUT != 0) begin : gen_reg_out
         logic res_reg;
         logic cry_reg;
         logic vld_reg;

         // Reset clears any in-flight result, so the first enabled edge
         // after reset produces a fresh result. Idle cycles drop valid
         // but keep the last result on the outputs.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               res_reg <= 1'b0;
               cry_reg <= 1'b0;
               vld_reg <= 1'b0;
            end else begin
               vld_reg <= bus.i_en;
               if (bus.i_en) begin
                  res_reg <= sum_c;
                  cry_reg <= cry_c;
               end
            end
         end

         assign bus.o_res = res_reg;
         assign bus.o_cry = cry_reg;
         assign bus.o_vld = vld_reg;
      end else begin : gen_comb_out
         // Pure function of the operands: not affected by clock, reset
         // or i_en.
         assign bus.o_res = sum_c;
         assign bus.o_cry = cry_c;
         assign bus.o_vld = bus.i_en;
      end
   endgenerate

endmodule

// File: tb/tb_add_1bit_half.sv
// -----------------------------------------------------------------------------
// tb_add_1bit_half
// Bench with three instances of the adder:
//   u_cmb : combinational result, 8-bit counter
//   u_reg : registered result,    8-bit counter
//   u_sat : registered result,    2-bit counter (saturation)
// Expected results are pushed to a scoreboard queue when stimulus is driven
// and popped when the DUT output is due.
// -----------------------------------------------------------------------------
module tb_add_1bit_half;

   logic clk;
   logic rst_n;

   add_1bit_half_if #(.P_CNT_W(8)) if_c ();
   add_1bit_half_if #(.P_CNT_W(8)) if_r ();
   add_1bit_half_if #(.P_CNT_W(2)) if_s ();

   add_1bit_half #(.P_REG_OUT(0), .P_CNT_W(8)) u_cmb (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));
   add_1bit_half #(.P_REG_OUT(1), .P_CNT_W(8)) u_reg (.i_clk(clk), .i_rst_n(rst_n), .bus(if_r));
   add_1bit_half #(.P_REG_OUT(1), .P_CNT_W(2)) u_sat (.i_clk(clk), .i_rst_n(rst_n), .bus(if_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        res;
      logic        cry;
      logic        vld;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model state for u_reg
   logic        mr_res, mr_cry, mr_vld;
   logic [31:0] mr_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) begin
         n_pass++;
         $display("PASS %s obs=%0h exp=%0h", tag, obs, exp_v);
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         e.tag = "none"; e.res = 1'b0; e.cry = 1'b0; e.vld = 1'b0; e.cnt = '0;
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic model_reset();
      mr_res = 1'b0; mr_cry = 1'b0; mr_vld = 1'b0; mr_cnt = '0;
   endtask

   // Combinational step: drive, then check one time unit later. No clock
   // edge is needed for this.
   task automatic cmb(input string tag, input logic en, input logic a, input logic b,
                      input logic res, input logic cry);
      exp_t e;
      if_c.i_en = en; if_c.i_num_a = a; if_c.i_num_b = b;
      e.tag = tag; e.res = res; e.cry = cry; e.vld = en; e.cnt = '0;
      sb.push_back(e);
      #1;
      pop_exp(e);
      chk({e.tag, ".res"}, 32'(if_c.o_res), 32'(e.res));
      chk({e.tag, ".cry"}, 32'(if_c.o_cry), 32'(e.cry));
      chk({e.tag, ".vld"}, 32'(if_c.o_vld), 32'(e.vld));
   endtask

   // Registered step: drive at the falling edge, let one rising edge pass,
   // then compare at the next falling edge.
   task automatic cyc_r(input string tag, input logic en, input logic a, input logic b);
      exp_t e;
      if_r.i_en = en; if_r.i_num_a = a; if_r.i_num_b = b;
      if (en) begin
         mr_res = a ^ b;
         mr_cry = a & b;
         if ((a & b) && (mr_cnt != 32'd255)) mr_cnt = mr_cnt + 32'd1;
      end
      mr_vld = en;
      e.tag = tag; e.res = mr_res; e.cry = mr_cry; e.vld = mr_vld; e.cnt = mr_cnt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      pop_exp(e);
      chk({e.tag, ".res"}, 32'(if_r.o_res), 32'(e.res));
      chk({e.tag, ".cry"}, 32'(if_r.o_cry), 32'(e.cry));
      chk({e.tag, ".vld"}, 32'(if_r.o_vld), 32'(e.vld));
      chk({e.tag, ".cnt"}, 32'(if_r.o_cnt_cry), e.cnt);
   endtask

   task automatic cyc_s(input string tag, input logic [31:0] exp_cnt);
      exp_t e;
      if_s.i_en = 1'b1; if_s.i_num_a = 1'b1; if_s.i_num_b = 1'b1;
      e.tag = tag; e.res = 1'b0; e.cry = 1'b1; e.vld = 1'b1; e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      pop_exp(e);
      chk({e.tag, ".cnt"}, 32'(if_s.o_cnt_cry), e.cnt);
      chk({e.tag, ".cry"}, 32'(if_s.o_cry), 32'(e.cry));
   endtask

   // Pulse reset mid-cycle and release it on the next falling edge.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] sat_tbl [6];
      sat_tbl[0] = 1; sat_tbl[1] = 2; sat_tbl[2] = 3;
      sat_tbl[3] = 3; sat_tbl[4] = 3; sat_tbl[5] = 3;

      rst_n = 1'b0;
      if_c.i_en = 1'b0; if_c.i_num_a = 1'b0; if_c.i_num_b = 1'b0;
      if_r.i_en = 1'b0; if_r.i_num_a = 1'b0; if_r.i_num_b = 1'b0;
      if_s.i_en = 1'b0; if_s.i_num_a = 1'b0; if_s.i_num_b = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.reg.res", 32'(if_r.o_res), 32'd0);
      chk("rst.reg.cry", 32'(if_r.o_cry), 32'd0);
      chk("rst.reg.vld", 32'(if_r.o_vld), 32'd0);
      chk("rst.reg.cnt", 32'(if_r.o_cnt_cry), 32'd0);
      chk("rst.sat.cnt", 32'(if_s.o_cnt_cry), 32'd0);
      chk("rst.cmb.cnt", 32'(if_c.o_cnt_cry), 32'd0);
      rst_n = 1'b1;

      // Exhaustive combinational truth table, one pair every 10 ns
      cmb("cmb.00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #9;
      cmb("cmb.01", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #9;
      cmb("cmb.10", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); #9;
      cmb("cmb.11", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); #9;

      // Combinational valid follows i_en, and the counter counts there too
      if_c.i_en = 1'b1; if_c.i_num_a = 1'b1; if_c.i_num_b = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("cmb.cnt2", 32'(if_c.o_cnt_cry), 32'd2);
      chk("cmb.vld_en", 32'(if_c.o_vld), 32'd1);
      if_c.i_en = 1'b0;
      #1;
      chk("cmb.vld_dis", 32'(if_c.o_vld), 32'd0);
      @(negedge clk);

      // Registered latency and hold behavior
      cyc_r("reg.lat11", 1'b1, 1'b1, 1'b1);
      cyc_r("reg.hold", 1'b0, 1'b0, 1'b0);
      cyc_r("reg.01", 1'b1, 1'b0, 1'b1);
      cyc_r("reg.10", 1'b1, 1'b1, 1'b0);
      cyc_r("reg.00", 1'b1, 1'b0, 1'b0);

      // Counter: 5 enabled carries, disabled carries ignored
      pulse_reset();
      cyc_r("cnt.a", 1'b1, 1'b1, 1'b1);
      cyc_r("cnt.b", 1'b1, 1'b1, 1'b0);
      cyc_r("cnt.c", 1'b1, 1'b1, 1'b1);
      cyc_r("cnt.d", 1'b1, 1'b0, 1'b1);
      cyc_r("cnt.e", 1'b1, 1'b1, 1'b1);
      cyc_r("cnt.dis1", 1'b0, 1'b1, 1'b1);
      cyc_r("cnt.dis2", 1'b0, 1'b1, 1'b1);
      cyc_r("cnt.f", 1'b1, 1'b1, 1'b1);
      cyc_r("cnt.g", 1'b1, 1'b1, 1'b0);
      cyc_r("cnt.h", 1'b1, 1'b1, 1'b1);
      chk("cnt.total5", 32'(if_r.o_cnt_cry), 32'd5);

      // X operands while idle must not disturb outputs or the counter
      cyc_r("xidle", 1'b0, 1'bx, 1'bx);

      // Saturation with a 2-bit counter
      pulse_reset();
      for (int i = 0; i < 6; i++) cyc_s($sformatf("sat.%0d", i), sat_tbl[i]);
      if_s.i_en = 1'b0;

      // Async reset mid-cycle with carry=1 and count=3
      pulse_reset();
      cyc_r("ar.1", 1'b1, 1'b1, 1'b1);
      cyc_r("ar.2", 1'b1, 1'b1, 1'b1);
      cyc_r("ar.3", 1'b1, 1'b1, 1'b1);
      if_r.i_en = 1'b0;
      if_c.i_en = 1'b1; if_c.i_num_a = 1'b1; if_c.i_num_b = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar.now.cry", 32'(if_r.o_cry), 32'd0);
      chk("ar.now.vld", 32'(if_r.o_vld), 32'd0);
      chk("ar.now.res", 32'(if_r.o_res), 32'd0);
      chk("ar.now.cnt", 32'(if_r.o_cnt_cry), 32'd0);
      chk("ar.cmb.res", 32'(if_c.o_res), 32'd1);
      chk("ar.cmb.vld", 32'(if_c.o_vld), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      if_c.i_en = 1'b0;
      cyc_r("ar.post01", 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
